// File: rtl/tea_stream.sv
// tea_stream: streaming TEA/XTEA block cipher core, one half-round per clock.
//
// A 64-bit block is accepted on an i_valid/o_in_ready handshake together with
// its key and mode bits. It is processed for 2*ROUNDS cycles, then presented
// on o_data/o_valid until the downstream takes it with i_out_ready.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_valid      input block valid
//   o_in_ready   core can accept a block (IDLE only)
//   i_data       block, v0 = [63:32], v1 = [31:0]
//   i_key        key, k[j] = i_key[32*j +: 32]
//   i_dec        1 = decrypt, sampled on accept
//   i_xtea       1 = XTEA, 0 = TEA, sampled on accept
//   o_valid      result valid (DONE)
//   i_out_ready  downstream accepts the result
//   o_data       result, packed like i_data
//   o_busy       high while rounds are running
//
// state | meaning
// IDLE  | waiting for a block, o_in_ready=1
// RUN   | one half-round per cycle, cnt 0..2*ROUNDS-1
// DONE  | result held on o_data until i_out_ready

module tea_stream #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9,
  parameter int unsigned CW     = $clog2(2 * ROUNDS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_in_ready,
  input  logic [63:0]   i_data,
  input  logic [127:0]  i_key,
  input  logic          i_dec,
  input  logic          i_xtea,
  output logic          o_valid,
  input  logic          i_out_ready,
  output logic [63:0]   o_data,
  output logic          o_busy
);

  // Decryption starts from the sum the encryption ends on (mod 2^32).
  localparam logic [31:0]   SUM_DEC  = 32'(DELTA * ROUNDS);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * ROUNDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   sum_q, v0_q, v1_q;
  logic [31:0]   k_q [4];
  logic          dec_q, xtea_q;
  logic          in_ready_q, valid_q, busy_q;
  logic [63:0]   data_q;

  logic [31:0]   sum_d, v0_d, v1_d;
  logic [31:0]   sum_add, sum_sub;

  function automatic logic [31:0] tea_f(input logic [31:0] x, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] s);
    return ((x << 4) + a) ^ (x + s) ^ ((x >> 5) + b);
  endfunction

  function automatic logic [31:0] xtea_g(input logic [31:0] x);
    return ((x << 4) ^ (x >> 5)) + x;
  endfunction

  // Half-round datapath; cnt_q[0] selects the even/odd half of a round pair.
  always_comb begin
    v0_d    = v0_q;
    v1_d    = v1_q;
    sum_d   = sum_q;
    sum_add = sum_q + DELTA;
    sum_sub = sum_q - DELTA;
    case ({xtea_q, dec_q, cnt_q[0]})
      3'b000: begin
        sum_d = sum_add;
        v0_d  = v0_q + tea_f(v1_q, k_q[0], k_q[1], sum_add);
      end
      3'b001: v1_d = v1_q + tea_f(v0_q, k_q[2], k_q[3], sum_q);
      3'b010: v1_d = v1_q - tea_f(v0_q, k_q[2], k_q[3], sum_q);
      3'b011: begin
        v0_d  = v0_q - tea_f(v1_q, k_q[0], k_q[1], sum_q);
        sum_d = sum_sub;
      end
      3'b100: begin
        v0_d  = v0_q + (xtea_g(v1_q) ^ (sum_q + k_q[sum_q[1:0]]));
        sum_d = sum_add;
      end
      3'b101: v1_d = v1_q + (xtea_g(v0_q) ^ (sum_q + k_q[sum_q[12:11]]));
      3'b110: begin
        v1_d  = v1_q - (xtea_g(v0_q) ^ (sum_q + k_q[sum_q[12:11]]));
        sum_d = sum_sub;
      end
      3'b111: v0_d = v0_q - (xtea_g(v1_q) ^ (sum_q + k_q[sum_q[1:0]]));
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sum_q      <= '0;
      v0_q       <= '0;
      v1_q       <= '0;
      for (int j = 0; j < 4; j++) k_q[j] <= '0;
      dec_q      <= 1'b0;
      xtea_q     <= 1'b0;
      in_ready_q <= 1'b1;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid && in_ready_q) begin
            v0_q       <= i_data[63:32];
            v1_q       <= i_data[31:0];
            for (int j = 0; j < 4; j++) k_q[j] <= i_key[32*j +: 32];
            dec_q      <= i_dec;
            xtea_q     <= i_xtea;
            cnt_q      <= '0;
            sum_q      <= i_dec ? SUM_DEC : 32'h0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          v0_q  <= v0_d;
          v1_q  <= v1_d;
          sum_q <= sum_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            data_q  <= {v0_d, v1_d};
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            valid_q    <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready = in_ready_q;
  assign o_valid    = valid_q;
  assign o_busy     = busy_q;
  assign o_data     = data_q;

endmodule
